// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change dispenser.
package vend_pkg;

    localparam int unsigned CHG_W_DEF = 3;

    // Coin values in nickel units
    localparam int unsigned NICKEL_U = 1;
    localparam int unsigned DIME_U   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SODA  = 3'd1,
        ST_SEL   = 3'd2,
        ST_REL   = 3'd3,
        ST_GAP   = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

endpackage

// File: rtl/vend_change_dispenser.sv
// Soda-drop motor plus coin-by-coin change payout from a dime/nickel hopper.
// Optional ack timeout in REL enabled by defining DISP_TIMEOUT_EN.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned SODA_CYCLES = 4,
    parameter int unsigned CHG_W       = CHG_W_DEF,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_soda,
    input  logic [CHG_W-1:0] i_change,
    input  logic             i_nickel_empty,
    input  logic             i_dime_empty,
    input  logic             i_coin_ack,
    input  logic             i_clr,
    output logic             o_soda_motor,
    output logic             o_nickel_rel,
    output logic             o_dime_rel,
    output logic             o_busy,
    output logic             o_fault,
    output logic             o_overrun,
    output logic [CHG_W-1:0] o_owed
);

    localparam int unsigned SCW = $clog2(SODA_CYCLES + 1);

    if (SODA_CYCLES < 1 || CHG_W < 2 || ACK_TIMEOUT < 1) begin : g_param_check
        $error("vend_change_dispenser: illegal parameter set");
    end

    state_t           state_q, state_nx;
    logic [CHG_W-1:0] rem_q, rem_nx;
    logic             dime_q, dime_nx;
    logic             pend_vld_q, pend_vld_nx;
    logic [CHG_W-1:0] pend_chg_q, pend_chg_nx;
    logic             ovr_nx;
    logic [SCW-1:0]   mcnt_q, mcnt_nx;

`ifdef DISP_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(ACK_TIMEOUT + 1);
    logic [TCW-1:0] tcnt_q, tcnt_nx;
`endif

    // Next-state, payout bookkeeping and the one-deep pending buffer
    always_comb begin
        state_nx    = state_q;
        rem_nx      = rem_q;
        dime_nx     = dime_q;
        pend_vld_nx = pend_vld_q;
        pend_chg_nx = pend_chg_q;
        ovr_nx      = o_overrun & ~i_clr;
        mcnt_nx     = '0;
`ifdef DISP_TIMEOUT_EN
        tcnt_nx     = '0;
`endif

        // A vend arriving mid-transaction is parked; a second one is lost
        if (i_soda && state_q != ST_IDLE) begin
            if (!pend_vld_q) begin
                pend_vld_nx = 1'b1;
                pend_chg_nx = i_change;
            end else begin
                ovr_nx = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    // Older parked vend goes first; a fresh pulse takes its slot
                    rem_nx      = pend_chg_q;
                    state_nx    = ST_SODA;
                    pend_vld_nx = i_soda;
                    if (i_soda) begin
                        pend_chg_nx = i_change;
                    end
                end else if (i_soda) begin
                    rem_nx   = i_change;
                    state_nx = ST_SODA;
                end
            end
            ST_SODA: begin
                if (mcnt_q == SCW'(SODA_CYCLES - 1)) begin
                    state_nx = ST_SEL;
                end else begin
                    mcnt_nx = mcnt_q + SCW'(1);
                end
            end
            ST_SEL: begin
                if (rem_q == '0) begin
                    state_nx = ST_IDLE;
                end else if (rem_q >= CHG_W'(DIME_U) && !i_dime_empty) begin
                    dime_nx  = 1'b1;
                    state_nx = ST_REL;
                end else if (!i_nickel_empty) begin
                    dime_nx  = 1'b0;
                    state_nx = ST_REL;
                end else begin
                    state_nx = ST_FAULT;
                end
            end
            ST_REL: begin
                if (i_coin_ack) begin
                    rem_nx   = rem_q - (dime_q ? CHG_W'(DIME_U) : CHG_W'(NICKEL_U));
                    state_nx = ST_GAP;
                end
`ifdef DISP_TIMEOUT_EN
                else if (tcnt_q == TCW'(ACK_TIMEOUT - 1)) begin
                    state_nx = ST_FAULT;
                end else begin
                    tcnt_nx = tcnt_q + TCW'(1);
                end
`else
                // Without a timeout the hopper is trusted to answer eventually
`endif
            end
            ST_GAP: begin
                state_nx = ST_SEL;
            end
            ST_FAULT: begin
                if (i_clr) begin
                    rem_nx   = '0;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs track the next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            dime_q       <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_chg_q   <= '0;
            mcnt_q       <= '0;
            o_soda_motor <= 1'b0;
            o_nickel_rel <= 1'b0;
            o_dime_rel   <= 1'b0;
            o_busy       <= 1'b0;
            o_fault      <= 1'b0;
            o_overrun    <= 1'b0;
            o_owed       <= '0;
        end else begin
            state_q      <= state_nx;
            rem_q        <= rem_nx;
            dime_q       <= dime_nx;
            pend_vld_q   <= pend_vld_nx;
            pend_chg_q   <= pend_chg_nx;
            mcnt_q       <= mcnt_nx;
            o_soda_motor <= (state_nx == ST_SODA);
            o_nickel_rel <= (state_nx == ST_REL) && !dime_nx;
            o_dime_rel   <= (state_nx == ST_REL) && dime_nx;
            o_busy       <= (state_nx != ST_IDLE);
            o_fault      <= (state_nx == ST_FAULT);
            o_overrun    <= ovr_nx;
            o_owed       <= (state_nx == ST_FAULT) ? rem_nx : '0;
        end
    end

`ifdef DISP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_nx;
        end
    end
`endif

endmodule
